// File: rtl/siso_link_sched_if.sv
// Bus bundle for siso_link_sched: requester handshake, SISO link pins and returned-word outputs.
// master = requesters plus external SISO register, slave = the scheduler.
interface siso_link_sched_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        req_ready;
    logic              shift_en;
    logic              ser_out;
    logic              ser_in;
    logic              busy;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_src;
    logic              rx_perr;

    modport master (
        output req_valid, req_data0, req_data1, ser_in,
        input  req_ready, shift_en, ser_out, busy, rx_valid, rx_data, rx_src, rx_perr
    );

    modport slave (
        input  req_valid, req_data0, req_data1, ser_in,
        output req_ready, shift_en, ser_out, busy, rx_valid, rx_data, rx_src, rx_perr
    );
endinterface

// File: rtl/siso_link_sched.sv
// Round-robin two-requester scheduler that serializes words MSB-first into an external SISO
// register and captures the loopback. Define SISO_LINK_PARITY_EN to append an even-parity bit.
module siso_link_sched #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    siso_link_sched_if.slave bus
);
`ifdef SISO_LINK_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int CNT_MAX = FRAME_LEN + DEPTH - 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 ptr;
    logic                 grant;
    logic                 xfer;
    logic                 last;
    logic [1:0]           ready;
    logic [DATA_W-1:0]    word;
    logic [FRAME_LEN-1:0] frame;
    logic [FRAME_LEN-2:0] tx_sh;
    logic [FRAME_LEN-2:0] rx_sh;
    logic [FRAME_LEN-1:0] rx_nxt;
    logic                 shift_en_r;
    logic                 ser_out_r;
    logic                 busy_r;
    logic                 rx_valid_r;
    logic                 rx_src_r;
    logic [DATA_W-1:0]    rx_data_r;

    assign last   = (state == SHIFT) && (int'(cnt) == CNT_MAX);
    assign rx_nxt = {rx_sh, bus.ser_in};

`ifdef SISO_LINK_PARITY_EN
    assign frame = {word, ^word};
`else
    assign frame = word;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant and handshake: the pointer's requester wins if valid, otherwise the other one
    always_comb begin
        grant = bus.req_valid[ptr] ? ptr : ~ptr;
        ready = 2'b00;
        if (state == IDLE && |bus.req_valid) begin
            ready[grant] = 1'b1;
        end
        xfer = |(ready & bus.req_valid);
        word = grant ? bus.req_data1 : bus.req_data0;
    end

    // Serializer / deserializer; outputs are registered from next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            ptr        <= 1'b0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            shift_en_r <= 1'b0;
            ser_out_r  <= 1'b0;
            busy_r     <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_src_r   <= 1'b0;
            rx_data_r  <= '0;
        end else begin
            rx_valid_r <= 1'b0;
            shift_en_r <= (state_nxt == SHIFT);
            busy_r     <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (xfer) begin
                        ser_out_r <= frame[FRAME_LEN-1];
                        tx_sh     <= frame[FRAME_LEN-2:0];
                        rx_src_r  <= grant;
                        ptr       <= ~grant;
                        cnt       <= '0;
                    end
                end
                SHIFT: begin
                    // Once the frame is exhausted, zeros flush the SISO register
                    ser_out_r <= (int'(cnt) + 1 < FRAME_LEN) ? tx_sh[FRAME_LEN-2] : 1'b0;
                    tx_sh     <= tx_sh << 1;
                    if (int'(cnt) >= DEPTH) begin
                        rx_sh <= rx_nxt[FRAME_LEN-2:0];
                    end
                    if (last) begin
                        rx_valid_r <= 1'b1;
                        rx_data_r  <= rx_nxt[FRAME_LEN-1 -: DATA_W];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SISO_LINK_PARITY_EN
    logic rx_perr_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_perr_r <= 1'b0;
        end else if (last) begin
            rx_perr_r <= ^rx_nxt;
        end
    end

    assign bus.rx_perr = rx_perr_r;
`else
    assign bus.rx_perr = 1'b0;
`endif

    assign bus.req_ready = ready;
    assign bus.shift_en  = shift_en_r;
    assign bus.ser_out   = ser_out_r;
    assign bus.busy      = busy_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_src    = rx_src_r;
endmodule

// File: tb/tb_siso_link_sched.sv
// Randomized bench for siso_link_sched with a DEPTH-stage SISO loop model and a
// frame-timeline reference model checked every cycle on the falling edge.
module tb_siso_link_sched;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef SISO_LINK_PARITY_EN
    localparam int FL  = DATA_W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = DATA_W;
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_CYC = FL + DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    siso_link_sched_if #(.DATA_W(DATA_W)) bus ();

    siso_link_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External SISO register plus link fault injection
    logic [DEPTH-1:0] siso = '0;
    logic stuck = 1'b0;
    int   flip_pos = -1;
    int   flip_cyc = -1;
    always @(posedge clk) if (bus.shift_en) siso <= {siso[DEPTH-2:0], bus.ser_out};
    assign bus.ser_in = stuck | (siso[DEPTH-1] ^ (cyc == flip_cyc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: one frame in flight, timed from its handshake cycle
    bit            active = 1'b0;
    int            t_hs = 0;
    bit            ptr_m = 1'b0;
    logic [FL-1:0] cur_fr;
    logic [FL-1:0] cur_cap;
    bit            cur_src;
    int            n_hs = 0;
    int            n_rx = 0;
    int            d;
    bit            idle;
    logic [1:0]    er;
    bit            eg;
    logic [DATA_W-1:0] w;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
            ptr_m  = 1'b0;
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_shift_en", bus.shift_en, 0);
            check("rst_ser_out", bus.ser_out, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_rx_valid", bus.rx_valid, 0);
            check("rst_rx_data", bus.rx_data, 0);
            check("rst_rx_src", bus.rx_src, 0);
            check("rst_rx_perr", bus.rx_perr, 0);
        end else begin
            d    = active ? (cyc - t_hs) : 1000000;
            idle = (d > FRAME_CYC + 1);
            check("shift_en", bus.shift_en, (d >= 1 && d <= FRAME_CYC));
            check("ser_out", bus.ser_out, (d >= 1 && d <= FL) ? cur_fr[FL-d] : 1'b0);
            check("busy", bus.busy, (d >= 1 && d <= FRAME_CYC + 1));
            check("rx_valid", bus.rx_valid, (d == FRAME_CYC + 1));
            if (d == FRAME_CYC + 1) begin
                n_rx++;
                check("rx_data", bus.rx_data, cur_cap[FL-1 -: DATA_W]);
                check("rx_src", bus.rx_src, cur_src);
                check("rx_perr", bus.rx_perr, PAR ? ^cur_cap : 1'b0);
            end
            er = 2'b00;
            if (idle && |bus.req_valid) begin
                eg = bus.req_valid[ptr_m] ? ptr_m : !ptr_m;
                er[eg] = 1'b1;
            end
            check("req_ready", bus.req_ready, er);
            if (er != 2'b00) begin
                w       = eg ? bus.req_data1 : bus.req_data0;
                cur_fr  = PAR ? FL'({w, ^w}) : FL'(w);
                cur_cap = stuck ? '1 : cur_fr;
                if (flip_pos >= 0) begin
                    cur_cap[FL-1-flip_pos] = ~cur_cap[FL-1-flip_pos];
                    flip_cyc = cyc + 1 + DEPTH + flip_pos;
                end
                cur_src = eg;
                ptr_m   = !eg;
                active  = 1'b1;
                t_hs    = cyc;
                n_hs++;
            end
        end
    end

    // Drivers run just after the rising edge
    task automatic send(input int src, input logic [DATA_W-1:0] word);
        int n0;
        n0 = n_hs;
        if (src == 0) bus.req_data0 = word; else bus.req_data1 = word;
        bus.req_valid[src] = 1'b1;
        for (int i = 0; i < 100 && n_hs == n0; i++) @(posedge clk);
        #1;
        bus.req_valid[src] = 1'b0;
        check("handshake_timeout", (n_hs != n0), 1);
    endtask

    task automatic wait_idle();
        repeat (FRAME_CYC + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        int rx0;
        bus.req_valid = 2'b00;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Continuous contention
        bus.req_data0 = 8'h3C;
        bus.req_data1 = 8'hC3;
        bus.req_valid = 2'b11;
        rx0 = n_rx;
        repeat (4 * (FRAME_CYC + 2)) @(posedge clk);
        #1 bus.req_valid = 2'b00;
        wait_idle();
        check("contention_frames", (n_rx - rx0 >= 4), 1);

        send(0, 8'hA5);
        wait_idle();

        // Requester 1 alone, repeated
        bus.req_data1 = 8'h01;
        bus.req_valid = 2'b10;
        repeat (3 * (FRAME_CYC + 2)) @(posedge clk);
        #1 bus.req_valid = 2'b00;
        wait_idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.req_data0 = 8'($urandom);
            bus.req_data1 = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        wait_idle();

        // Broken link, then one corrupted capture
        stuck = 1'b1;
        send(0, 8'h00);
        wait_idle();
        stuck = 1'b0;
        flip_pos = 3;
        send(1, 8'h07);
        flip_pos = -1;
        wait_idle();
        send(0, 8'h07);
        wait_idle();

        // Reset mid-frame at cnt = 5
        send(1, 8'h33);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'h5A);
        wait_idle();

        check("frames_seen", (n_rx >= 20), 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/siso_link_sched.md
# siso_link_sched

Two-requester scheduler and sequencer for a serial-in serial-out shift-register link. It arbitrates between two parallel word sources and serializes the winning word MSB-first into an external SISO register by driving that register's shift enable and serial input. It captures the register's serial output back into a parallel receive word, giving a loopback check of the shift path. It sits between the block's word producers and the shift-register datapath.

## Interface
- DATA_W, 8, word width in bits (>= 2)
- DEPTH, 4, stage count of the driven SISO register (>= 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester word valid
- req_data0  input  DATA_W  requester 0 word
- req_data1  input  DATA_W  requester 1 word
- req_ready  output  2  per-requester accept (combinational; transfer when valid & ready)
- shift_en  output  1  shift enable to the SISO register
- ser_out  output  1  serial data to the SISO register input
- ser_in  input  1  serial output from the SISO register (its MSB stage)
- busy  output  1  high when not IDLE
- rx_valid  output  1  one-cycle pulse: returned word valid
- rx_data  output  DATA_W  returned word
- rx_src  output  1  requester index of the returned word
- rx_perr  output  1  parity error flag, qualified by rx_valid

## Operation
- FRAME_LEN = DATA_W (DATA_W+1 with parity); counter cnt counts 0 .. FRAME_LEN+DEPTH-1.
- States: IDLE, SHIFT, DONE.
- IDLE: if any req_valid, grant per round-robin pointer ptr. If ptr's requester is valid, grant it; otherwise grant the other. req_ready[grant] = 1 in the same cycle. On transfer: latch word into tx shift register, latch rx_src = grant, set ptr = ~grant, cnt = 0, go to SHIFT.
- SHIFT: shift_en = 1 every cycle.
  - ser_out = tx MSB while cnt < FRAME_LEN, then 0 (flush bits).
  - When cnt >= DEPTH, shift ser_in into the rx shift register LSB-side.
  - At cnt = FRAME_LEN+DEPTH-1, go to DONE; otherwise cnt++.
- DONE: shift_en = 0; rx_valid = 1 for one cycle with rx_data and rx_src; go to IDLE unconditionally; no grant in DONE.
- req_ready = 0 outside IDLE. ptr is unchanged when there is no transfer.
- shift_en is never deasserted mid-frame, so the bit driven at cnt = k is sampled from ser_in at cnt = k+DEPTH.

## Timing
- Reset values:
  - state IDLE, ptr 0, busy 0, shift_en 0, ser_out 0
  - rx_valid 0, rx_data 0, rx_src 0, rx_perr 0
  - req_ready follows IDLE grant logic; requesters keep req_valid low during reset
- All outputs except req_ready are registered.
- Frame timeline, handshake at cycle T:
  - SHIFT occupies cycles T+1 .. T+FRAME_LEN+DEPTH
  - DONE/rx_valid at T+FRAME_LEN+DEPTH+1
  - next handshake earliest at T+FRAME_LEN+DEPTH+2
- Simultaneous valid: ptr decides; strict alternation under continuous contention.
- Reset mid-frame: all state returns to reset values immediately and no rx_valid is issued. The SISO register content is not flushed by this block; the next frame's DEPTH flush cycles overwrite it.
- ser_in is ignored outside SHIFT captures.

## Configuration
- SISO_LINK_PARITY_EN defined:
  - An even-parity bit (XOR of the word) is shifted after the word LSB; FRAME_LEN = DATA_W+1.
  - rx captures FRAME_LEN bits; rx_data = first DATA_W captured bits.
  - rx_perr = XOR of all captured bits, valid with rx_valid.
- Undefined: FRAME_LEN = DATA_W; rx_perr tied 0.

## Test plan
- Single frame, DATA_W=8, DEPTH=4, 4-stage SISO model in loop. req0 sends 0xA5 at T → shift_en high T+1..T+12; ser_out = 1,0,1,0,0,1,0,1,0,0,0,0; rx_valid at T+13 with rx_data 0xA5, rx_src 0.
- Contention: both valid continuously from reset (0x3C / 0xC3) → grants alternate 0,1,0,1; rx_src alternates; rx_data matches the source word; handshakes spaced 14 cycles.
- Single requester repeat: only req1 valid with 0x01 → granted every 14 cycles, rx_data 0x01, rx_src 1.
- Broken link: ser_in stuck 1, send 0x00 → rx_data 0xFF, rx_valid single pulse.
- Reset mid-frame: assert rst_n low at SHIFT cnt=5 → all outputs 0 next sample, no rx_valid. After release, send 0x5A → rx_data 0x5A.
- Parity build (SISO_LINK_PARITY_EN): send 0x07 → 9th ser_out bit 1, 13 SHIFT cycles, rx_perr 0. Force ser_in inverted for one capture → rx_perr 1.
